// File: rtl/avalon_arbiter_rr.sv
// Two-master round-robin arbiter in front of a single Avalon-MM slave.
// Grants are registered (one cycle of arbitration latency). An idle cycle
// always separates transfers. An optional watchdog aborts transfers that
// the slave never acknowledges and sets a sticky error flag.
module avalon_arbiter_rr #(
  parameter int unsigned AW = 1,
  parameter int unsigned DW = 8,
  parameter int unsigned TO = 0,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_read,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_address,
  input  logic [DW-1:0] m0_writedata,
  output logic [DW-1:0] m0_readdata,
  output logic          m0_waitrequest,

  input  logic          m1_read,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_address,
  input  logic [DW-1:0] m1_writedata,
  output logic [DW-1:0] m1_readdata,
  output logic          m1_waitrequest,

  output logic          s_read,
  output logic          s_write,
  output logic [AW-1:0] s_address,
  output logic [DW-1:0] s_writedata,
  input  logic [DW-1:0] s_readdata,
  input  logic          s_waitrequest,

  output logic [1:0]    grant,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // Watchdog is compiled out when TO is zero; WD_LAST is the counter value
  // seen during the TO-th consecutive stalled cycle.
  localparam bit            WD_EN   = (TO != 0);
  localparam logic [CW-1:0] WD_LAST = WD_EN ? CW'(TO - 1) : '0;

  state_t        state_q;
  logic [1:0]    grant_q;
  logic          ptr_q;      // 0: m0 wins a tie, 1: m1 wins a tie
  logic [CW-1:0] wd_cnt_q;
  logic          err_q;

  logic req0;
  logic req1;
  logic own0;
  logic own1;
  logic own_req;
  logic done;
  logic wd_hit;
  logic own_end;

  // Slave-side mux, master-side response routing and transfer-end detection.
  always_comb begin
    req0           = m0_read | m0_write;
    req1           = m1_read | m1_write;
    own0           = (state_q == OWN0);
    own1           = (state_q == OWN1);

    own_req        = 1'b0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_address      = '0;
    s_writedata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;

    if (own0) begin
      own_req     = req0;
      s_write     = m0_write;
      s_read      = m0_read & ~m0_write;
      s_address   = m0_address;
      s_writedata = m0_writedata;
    end else if (own1) begin
      own_req     = req1;
      s_write     = m1_write;
      s_read      = m1_read & ~m1_write;
      s_address   = m1_address;
      s_writedata = m1_writedata;
    end

    done    = (s_read | s_write) & ~s_waitrequest;
    wd_hit  = WD_EN && (own0 || own1) && own_req && s_waitrequest
              && (wd_cnt_q == WD_LAST);
    // A dropped request ends ownership too, so the arbiter cannot stall on
    // a master that walked away.
    own_end = done | wd_hit | ~own_req;

    // A watchdog abort looks like a completion carrying zero read data.
    if (own0) begin
      m0_waitrequest = s_waitrequest & ~wd_hit;
      m0_readdata    = wd_hit ? '0 : s_readdata;
    end
    if (own1) begin
      m1_waitrequest = s_waitrequest & ~wd_hit;
      m1_readdata    = wd_hit ? '0 : s_readdata;
    end
  end

  // Ownership FSM with round-robin pointer, watchdog counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= 2'b00;
      ptr_q    <= 1'b0;
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wd_cnt_q <= '0;
          if (req0 && (!req1 || !ptr_q)) begin
            state_q <= OWN0;
            grant_q <= 2'b01;
            ptr_q   <= 1'b1;
          end else if (req1) begin
            state_q <= OWN1;
            grant_q <= 2'b10;
            ptr_q   <= 1'b0;
          end
        end
        OWN0, OWN1: begin
          if (own_end) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            wd_cnt_q <= '0;
            err_q    <= err_q | wd_hit;
          end else if (WD_EN && s_waitrequest) begin
            wd_cnt_q <= wd_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          grant_q  <= 2'b00;
          wd_cnt_q <= '0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign err   = err_q;

endmodule

// File: tb/tb_avalon_arbiter_rr.sv
// Directed bench for avalon_arbiter_rr. The main instance has an 8-cycle
// watchdog; a second instance with the watchdog disabled shares its inputs.
module tb_avalon_arbiter_rr;

  localparam int unsigned AW = 1;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [AW-1:0] m0_address, m1_address;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic [DW-1:0] s_readdata;
  logic          s_waitrequest;

  logic [DW-1:0] m0_readdata, m1_readdata, s_writedata;
  logic          m0_waitrequest, m1_waitrequest, s_read, s_write, err;
  logic [AW-1:0] s_address;
  logic [1:0]    grant;

  logic [DW-1:0] d0_m0_readdata, d0_m1_readdata, d0_s_writedata;
  logic          d0_m0_waitrequest, d0_m1_waitrequest, d0_s_read, d0_s_write, d0_err;
  logic [AW-1:0] d0_s_address;
  logic [1:0]    d0_grant;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0]    exp_g [8];
  logic [DW-1:0] exp_d [8];

  always #5 clk = ~clk;

  avalon_arbiter_rr #(.AW(AW), .DW(DW), .TO(8), .CW(16)) dut (
    .clk(clk), .rst(rst),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_writedata(m0_writedata), .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_writedata(m1_writedata), .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_read(s_read), .s_write(s_write), .s_address(s_address), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(grant), .err(err)
  );

  avalon_arbiter_rr #(.AW(AW), .DW(DW), .TO(0), .CW(16)) dut0 (
    .clk(clk), .rst(rst),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_writedata(m0_writedata), .m0_readdata(d0_m0_readdata), .m0_waitrequest(d0_m0_waitrequest),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_writedata(m1_writedata), .m1_readdata(d0_m1_readdata), .m1_waitrequest(d0_m1_waitrequest),
    .s_read(d0_s_read), .s_write(d0_s_write), .s_address(d0_s_address), .s_writedata(d0_s_writedata),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(d0_grant), .err(d0_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_g = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2};
    exp_d = '{8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h11, 8'h00, 8'h22};

    rst = 1'b1;
    m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0;
    s_readdata = '0; s_waitrequest = 1'b0;

    // Reset state, with m0 requesting while held in reset
    tick(); tick();
    m0_write = 1; m0_writedata = 8'hA5;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_err", err, 1'b0);
    chk("rst_s_write", s_write, 1'b0);
    chk("rst_s_read", s_read, 1'b0);
    chk("rst_s_wdata", s_writedata, 8'h00);
    chk("rst_m0_wait", m0_waitrequest, 1'b1);
    chk("rst_m0_rdata", m0_readdata, 8'h00);
    m0_write = 0; m0_writedata = '0;
    tick();
    rst = 1'b0;

    // Single write from m0
    tick();
    m0_write = 1; m0_address = 1'b0; m0_writedata = 8'hA5; s_waitrequest = 0;
    #1;
    chk("wr_req_grant", grant, 2'b00);
    chk("wr_req_s_write", s_write, 1'b0);
    chk("wr_req_m0_wait", m0_waitrequest, 1'b1);
    tick(); #1;
    chk("wr_grant", grant, 2'b01);
    chk("wr_s_write", s_write, 1'b1);
    chk("wr_s_wdata", s_writedata, 8'hA5);
    chk("wr_m0_wait", m0_waitrequest, 1'b0);
    tick();
    m0_write = 0; m0_writedata = '0;
    #1;
    chk("wr_done_grant", grant, 2'b00);
    chk("wr_done_s_write", s_write, 1'b0);

    // Continuous contention from reset: m0, idle, m1, idle, ...
    tick();
    rst = 1'b1; #1; rst = 1'b0;
    m0_write = 1; m0_writedata = 8'h11;
    m1_write = 1; m1_writedata = 8'h22;
    s_waitrequest = 0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) tick();
      #1;
      chk("cont_grant", grant, exp_g[i]);
      chk("cont_s_wdata", s_writedata, exp_d[i]);
      chk("cont_s_write", s_write, exp_g[i] != 2'd0);
      chk("cont_m1_wait", m1_waitrequest, exp_g[i] != 2'd2);
    end
    tick();
    m0_write = 0; m1_write = 0; m0_writedata = '0; m1_writedata = '0;

    // Read routing to m1 after 4 stalled cycles, m0 requesting meanwhile
    tick();
    m1_read = 1; m1_address = 1'b1; s_waitrequest = 1; s_readdata = 8'h00;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) m0_write = 1;
      #1;
      chk("rd_stall_grant", grant, 2'b10);
      chk("rd_stall_s_read", s_read, 1'b1);
      chk("rd_stall_s_addr", s_address, 1'b1);
      chk("rd_stall_m1_wait", m1_waitrequest, 1'b1);
      chk("rd_stall_m0_wait", m0_waitrequest, 1'b1);
    end
    tick();
    s_waitrequest = 0; s_readdata = 8'h3C;
    #1;
    chk("rd_m1_rdata", m1_readdata, 8'h3C);
    chk("rd_m1_wait", m1_waitrequest, 1'b0);
    chk("rd_m0_rdata", m0_readdata, 8'h00);
    chk("rd_m0_wait", m0_waitrequest, 1'b1);
    tick();
    m1_read = 0;
    #1;
    chk("rd_idle_grant", grant, 2'b00);
    chk("rd_idle_m1_rdata", m1_readdata, 8'h00);
    chk("rd_idle_m0_wait", m0_waitrequest, 1'b1);
    tick(); #1;
    chk("rd_next_grant", grant, 2'b01);
    chk("rd_next_s_write", s_write, 1'b1);
    tick();
    m0_write = 0; s_readdata = '0;

    // Read/write collision: write wins
    tick();
    m0_read = 1; m0_write = 1; m0_writedata = 8'h5C; s_waitrequest = 0;
    tick(); #1;
    chk("coll_s_write", s_write, 1'b1);
    chk("coll_s_read", s_read, 1'b0);
    tick();
    m0_read = 0; m0_write = 0;

    // Withdrawal while stalled
    tick();
    m1_read = 1; s_waitrequest = 1;
    tick(); #1;
    chk("wd_own_grant", grant, 2'b10);
    tick();
    m1_read = 0;
    #1;
    chk("wdraw_s_read", s_read, 1'b0);
    tick(); #1;
    chk("wdraw_grant", grant, 2'b00);
    chk("wdraw_err", err, 1'b0);

    // Watchdog: slave stalls forever, abort in the 8th stalled cycle
    m0_write = 1; m0_writedata = 8'h5A; s_readdata = 8'hFF;
    for (int i = 1; i <= 7; i++) begin
      tick(); #1;
      chk("wdog_stall_grant", grant, 2'b01);
      chk("wdog_stall_m0_wait", m0_waitrequest, 1'b1);
      chk("wdog_stall_err", err, 1'b0);
    end
    tick(); #1;
    chk("wdog_hit_m0_wait", m0_waitrequest, 1'b0);
    chk("wdog_hit_m0_rdata", m0_readdata, 8'h00);
    chk("wdog_hit_s_write", s_write, 1'b1);
    chk("wdog_off_m0_wait", d0_m0_waitrequest, 1'b1);
    tick();
    m0_write = 0; m1_write = 1; m1_writedata = 8'h77; s_waitrequest = 0; s_readdata = '0;
    #1;
    chk("wdog_err", err, 1'b1);
    chk("wdog_s_write", s_write, 1'b0);
    chk("wdog_grant", grant, 2'b00);
    chk("wdog_off_err", d0_err, 1'b0);
    tick(); #1;
    chk("wdog_m1_grant", grant, 2'b10);
    chk("wdog_m1_s_wdata", s_writedata, 8'h77);
    chk("wdog_m1_wait", m1_waitrequest, 1'b0);
    tick();
    m1_write = 0;
    #1;
    chk("wdog_err_sticky", err, 1'b1);
    chk("wdog_off_err2", d0_err, 1'b0);

    // Async reset during an OWN1 stall
    tick(); tick();
    m1_read = 1; s_waitrequest = 1;
    tick(); #1;
    chk("arst_pre_grant", grant, 2'b10);
    chk("arst_pre_s_read", s_read, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    chk("arst_s_read", s_read, 1'b0);
    chk("arst_s_write", s_write, 1'b0);
    chk("arst_grant", grant, 2'b00);
    chk("arst_err", err, 1'b0);
    m0_write = 1; m0_writedata = 8'h99;
    tick();
    rst = 1'b0;
    tick(); #1;
    chk("arst_first_grant", grant, 2'b01);
    chk("arst_first_wdata", s_writedata, 8'h99);
    s_waitrequest = 0;
    tick();
    m0_write = 0; m1_read = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
